// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: waits for a stable clock-generator lock, releases the SoC
// reset, then enables instruction fetch. Any lock loss after release forces
// a one-cycle RELOCK pulse and a full restart of the sequence.
module boot_seq_ctrl #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RST_TO_FETCH_CYCLES = 16,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       core_clk,
  input  logic       reset_n,
  input  logic       mmcm_locked,
  input  logic       fetch_hold,
  output logic       soc_reset_n,
  output logic       fetch_enable,
  output logic       boot_done,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    RELOCK    = 3'd4
  } state_e;

  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] FETCH_LAST  = 16'(RST_TO_FETCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   srn_d, fe_d, bd_d;
  logic [7:0]             llc_d;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign seq_state = state_q;

  // Bring the asynchronous lock flag into the core_clk domain.
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], mmcm_locked};
  end

  // Next state, shared counter and output values derived from the next state,
  // so the registered outputs always agree with the state they accompany.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: if (lock_s) state_d = STABLE;
      STABLE: begin
        // Lock loss wins over an expiring count.
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RELEASE;
        else                         cnt_d   = cnt_q + 16'd1;
      end
      RELEASE: begin
        if (!lock_s)                 state_d = RELOCK;
        else if (cnt_q == FETCH_LAST) begin
          // Counter parks at terminal while a debug hold is active.
          if (!fetch_hold)           state_d = RUN;
        end
        else                         cnt_d   = cnt_q + 16'd1;
      end
      RUN:     if (!lock_s) state_d = RELOCK;
      RELOCK:  state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
    if (state_d != state_q) cnt_d = '0;

    srn_d = (state_d == RELEASE) || (state_d == RUN);
    bd_d  = (state_d == RUN);
    fe_d  = (state_d == RUN) && !fetch_hold;

    // Only RELEASE and RUN can lead into RELOCK, so each entry is one loss.
    llc_d = lock_loss_cnt;
    if (state_d == RELOCK && state_q != RELOCK && lock_loss_cnt != 8'hFF)
      llc_d = lock_loss_cnt + 8'd1;
  end

  // State, counter and output registers, all cleared asynchronously.
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      soc_reset_n   <= 1'b0;
      fetch_enable  <= 1'b0;
      boot_done     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      soc_reset_n   <= srn_d;
      fetch_enable  <= fe_d;
      boot_done     <= bd_d;
      lock_loss_cnt <= llc_d;
    end
  end

endmodule

// File: doc/boot_seq_ctrl.md
BOOT_SEQ_CTRL -- requirements
Module: boot_seq_ctrl

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 1024: cycles the synchronised lock must stay high before the SoC reset is released; legal range 1..65535.
REQ-002 Parameter RST_TO_FETCH_CYCLES, default 16: cycles between SoC reset release and fetch_enable assertion; legal range 1..65535.
REQ-003 Parameter SYNC_STAGES, default 2: flip-flop depth of the mmcm_locked synchroniser; legal range 2..4.
REQ-004 core_clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is sampled on core_clk.
REQ-006 mmcm_locked  input  1  clock-generator lock status; asynchronous to core_clk.
REQ-007 fetch_hold  input  1  synchronous debug hold; 1 blocks or withdraws fetch_enable.
REQ-008 soc_reset_n  output  1  registered active-low reset to the SoC core and peripherals.
REQ-009 fetch_enable  output  1  registered fetch enable to the core.
REQ-010 boot_done  output  1  registered; 1 only in RUN.
REQ-011 lock_loss_cnt  output  8  saturating count of lock losses after reset release.
REQ-012 seq_state  output  3  current state encoding: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3, RELOCK=4.

Function
REQ-013 mmcm_locked passes through a SYNC_STAGES flip-flop chain; lock_s is the last stage, so it lags the input by SYNC_STAGES edges.
REQ-014 One 16-bit cycle counter is shared by STABLE and RELEASE and is cleared on every state change.
REQ-015 Outputs are registered and updated on the same edge as the state register, so output values always match the current state.
REQ-016 WAIT_LOCK: soc_reset_n=0, fetch_enable=0; lock_s=1 -> STABLE.
REQ-017 STABLE: soc_reset_n=0; the counter increments each cycle; lock_s=0 -> WAIT_LOCK; the counter reaching LOCK_STABLE_CYCLES-1 with lock_s=1 -> RELEASE, so the FSM spends exactly LOCK_STABLE_CYCLES cycles in STABLE.
REQ-018 RELEASE: soc_reset_n=1, fetch_enable=0; lock_s=0 -> RELOCK.
REQ-019 RELEASE counting: the counter increments until it reaches RST_TO_FETCH_CYCLES-1 and then holds.
REQ-020 RELEASE exit: with the counter at terminal and fetch_hold=0 -> RUN; with fetch_hold=1 the FSM stays in RELEASE.
REQ-021 RUN: soc_reset_n=1, boot_done=1, fetch_enable = NOT fetch_hold, registered with 1-cycle latency; lock_s=0 -> RELOCK.
REQ-022 RELOCK: soc_reset_n=0, fetch_enable=0, boot_done=0 for exactly one cycle, then unconditionally -> WAIT_LOCK.
REQ-023 On every RELEASE->RELOCK or RUN->RELOCK transition, lock_loss_cnt increments by 1; it saturates at 255 and never wraps.
REQ-024 Lock loss takes priority over counter expiry in the same cycle: lock_s=0 at terminal count in STABLE -> WAIT_LOCK; in RELEASE -> RELOCK.
REQ-025 fetch_hold has no effect in WAIT_LOCK, STABLE or RELOCK.
REQ-026 Lock glitches shorter than one core_clk period may be missed; no filtering beyond the synchroniser is provided.

Reset
REQ-027 While reset_n=0, asynchronously: state=WAIT_LOCK, counter=0, synchroniser=0, soc_reset_n=0, fetch_enable=0, boot_done=0, lock_loss_cnt=0, seq_state=0.
REQ-028 Reset asserted mid-sequence (any state) returns all outputs to their reset values immediately, without waiting for a core_clk edge.
REQ-029 After reset_n deasserts, the full sequence restarts from WAIT_LOCK; lock_loss_cnt is not preserved.

Verification (LOCK_STABLE_CYCLES=8, RST_TO_FETCH_CYCLES=4, SYNC_STAGES=2)
REQ-030 Nominal boot: mmcm_locked rises at edge t -> STABLE at t+3, soc_reset_n=1 at t+11, fetch_enable=1 and boot_done=1 at t+15.
REQ-031 Lock drops for 3 cycles during STABLE count 5 -> return to WAIT_LOCK, counter cleared, full 8-cycle STABLE on relock, lock_loss_cnt stays 0.
REQ-032 Lock drops in RUN -> RELOCK for 1 cycle with soc_reset_n=0 and fetch_enable=0, then WAIT_LOCK, lock_loss_cnt=1; relock repeats the REQ-030 timing.
REQ-033 fetch_hold=1 held through RELEASE -> FSM waits in RELEASE with soc_reset_n=1; fetch_hold falls at edge u -> RUN at u+1 and fetch_enable=1 at u+1.
REQ-034 fetch_hold pulsed for 2 cycles in RUN -> fetch_enable low for 2 cycles delayed by 1, while soc_reset_n and boot_done stay 1.
REQ-035 300 lock losses from RUN -> lock_loss_cnt=255; reset_n pulse mid-RELEASE -> all outputs 0 asynchronously and lock_loss_cnt=0.
